// File: rtl/hd44780_nybble_sender.sv
// Drives HD44780 pins in 4-bit mode: one byte (or one init nybble) per request, E-strobed with timed waits.
// Busy for 2*(T_AS+T_EH+T_EL)+WAIT cycles per byte; o_ready low from accept edge until back in IDLE.
module hd44780_nybble_sender #(
    parameter int T_AS_CYC         = 3,
    parameter int T_EH_CYC         = 16,
    parameter int T_EL_CYC         = 16,
    parameter int T_SHORT_WAIT_CYC = 2016,
    parameter int T_LONG_WAIT_CYC  = 76800,
    parameter int CTR_BITS         = 17
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [7:0] i_data,
    input  logic       i_rs,
    input  logic       i_nybble_only,
    input  logic       i_long_wait,
    output logic       o_lcd_rs,
    output logic       o_lcd_e,
    output logic [3:0] o_lcd_data,
    output logic       o_busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_EH    = 3'd2;
    localparam logic [2:0] S_EL    = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    localparam logic [CTR_BITS-1:0] AS_LD = CTR_BITS'(T_AS_CYC - 1);
    localparam logic [CTR_BITS-1:0] EH_LD = CTR_BITS'(T_EH_CYC - 1);
    localparam logic [CTR_BITS-1:0] EL_LD = CTR_BITS'(T_EL_CYC - 1);
    localparam logic [CTR_BITS-1:0] SW_LD = CTR_BITS'(T_SHORT_WAIT_CYC - 1);
    localparam logic [CTR_BITS-1:0] LW_LD = CTR_BITS'(T_LONG_WAIT_CYC - 1);
    localparam logic [CTR_BITS-1:0] ONE   = CTR_BITS'(1);

    logic [2:0]          state;
    logic [CTR_BITS-1:0] ctr;
    logic [3:0]          lo_nyb;
    logic                phase_lo;
    logic                nyb_only;
    logic                long_wait;
    logic                ctr_done;

    assign ctr_done = (ctr == '0);

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state      <= S_IDLE;
            ctr        <= '0;
            lo_nyb     <= '0;
            phase_lo   <= 1'b0;
            nyb_only   <= 1'b0;
            long_wait  <= 1'b0;
            o_ready    <= 1'b1;
            o_busy     <= 1'b0;
            o_lcd_e    <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid && o_ready) begin
                        state      <= S_SETUP;
                        ctr        <= AS_LD;
                        o_lcd_rs   <= i_rs;
                        o_lcd_data <= i_data[7:4];
                        lo_nyb     <= i_data[3:0];
                        nyb_only   <= i_nybble_only;
                        long_wait  <= i_long_wait;
                        phase_lo   <= 1'b0;
                        o_ready    <= 1'b0;
                        o_busy     <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (ctr_done) begin
                        state   <= S_EH;
                        ctr     <= EH_LD;
                        o_lcd_e <= 1'b1;
                    end else begin
                        ctr <= ctr - ONE;
                    end
                end
                S_EH: begin
                    if (ctr_done) begin
                        state   <= S_EL;
                        ctr     <= EL_LD;
                        o_lcd_e <= 1'b0;
                    end else begin
                        ctr <= ctr - ONE;
                    end
                end
                S_EL: begin
                    // RS/data stay put through E low so the hold time is covered.
                    if (ctr_done) begin
                        if (!phase_lo && !nyb_only) begin
                            state      <= S_SETUP;
                            ctr        <= AS_LD;
                            phase_lo   <= 1'b1;
                            o_lcd_data <= lo_nyb;
                        end else begin
                            state <= S_WAIT;
                            ctr   <= long_wait ? LW_LD : SW_LD;
                        end
                    end else begin
                        ctr <= ctr - ONE;
                    end
                end
                S_WAIT: begin
                    if (ctr_done) begin
                        state   <= S_IDLE;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                    end else begin
                        ctr <= ctr - ONE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ctr     <= '0;
                    o_lcd_e <= 1'b0;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
